i2s_rx: RTL and testbench



---
 rtl/i2s_rx_pkg.sv | 20 ++
 rtl/i2s_rx_fifo.sv | 73 +++++++
 rtl/i2s_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared types and constants for the I2S slave receiver.
package i2s_rx_pkg;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DATA_W_DEF  = 16;

    // Receiver framing state.
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

    // Default-width stereo pair; modules with another DATA_W declare their own.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] left;
        logic [DATA_W_DEF-1:0] right;
    } pair_def_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// i2s_rx_fifo: synchronous FIFO of stereo pairs (used with I2S_RX_FIFO_EN).
// A push while full is dropped unless a pop happens in the same cycle.
module i2s_rx_fifo
    import i2s_rx_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter type         pair_t = pair_def_t
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_push,
    input  pair_t i_data,
    input  logic  i_pop,
    output pair_t o_data,
    output logic  o_empty,
    output logic  o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pair_t             mem_q [DEPTH];
    pair_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push_c;
    logic              do_pop_c;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_data  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_pop_c  = i_pop & ~o_empty;
        do_push_c = i_push & (~o_full | do_pop_c);
        if (do_push_c) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples SCK/WS/SD in i_clk, deserialises
// left/right words MSB-first and presents stereo pairs on a valid/ready stream.
// Build option I2S_RX_FIFO_EN buffers FIFO_DEPTH pairs; otherwise a single
// holding register is used.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_sck,
    input  logic              i_ws,
    input  logic              i_sd,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_ovf,
    input  logic              i_ovf_clr
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    typedef struct packed {
        logic [DATA_W-1:0] left;
        logic [DATA_W-1:0] right;
    } pair_t;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("i2s_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
    logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;
    logic                   sck_dly_q,  sck_dly_d;
    logic                   ws_cur_q,   ws_cur_d;
    logic                   bit_evt_c;
    logic                   ws_s_c;
    logic                   sd_s_c;

    rx_state_t              state_q, state_d;
    logic [DATA_W-1:0]      word_q, word_d;
    logic [DATA_W-1:0]      left_hold_q, left_hold_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]      word_ins_c;
    logic [CNT_W-1:0]       cnt_inc_c;
    logic                   ws_rise_c;
    logic                   ws_fall_c;
    logic                   push_c;
    pair_t                  push_pair_c;

    logic                   pop_c;
    logic                   ovf_evt_c;
    logic                   ovf_q, ovf_d;

    // Synchroniser chains plus one extra SCK stage for rising-edge detection.
    always_comb begin
        sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], i_sck};
        ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0],  i_ws};
        sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0],  i_sd};
        sck_dly_d  = sck_sync_q[SYNC_STAGES-1];
        ws_s_c     = ws_sync_q[SYNC_STAGES-1];
        sd_s_c     = sd_sync_q[SYNC_STAGES-1];
        bit_evt_c  = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
        ws_cur_d   = bit_evt_c ? ws_s_c : ws_cur_q;
        ws_rise_c  = ~ws_cur_q & ws_s_c;
        ws_fall_c  = ws_cur_q & ~ws_s_c;
    end

    // Framing FSM: shift bits of the channel owning the slot, latch words on WS change.
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        left_hold_d = left_hold_q;
        push_c      = 1'b0;
        word_ins_c  = word_q;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (cnt_q == CNT_W'(DATA_W - 1 - i)) begin
                word_ins_c[i] = sd_s_c;
            end
        end
        cnt_inc_c         = (cnt_q == CNT_W'(DATA_W)) ? cnt_q : cnt_q + CNT_W'(1);
        push_pair_c.left  = left_hold_q;
        push_pair_c.right = word_ins_c;

        if (!i_en) begin
            state_d = SYNC;
            word_d  = '0;
            cnt_d   = '0;
        end else if (bit_evt_c) begin
            case (state_q)
                SYNC: begin
                    if (ws_fall_c) begin
                        word_d  = '0;
                        cnt_d   = '0;
                        state_d = LEFT;
                    end
                end
                LEFT: begin
                    if (ws_rise_c) begin
                        left_hold_d = word_ins_c;
                        word_d      = '0;
                        cnt_d       = '0;
                        state_d     = RIGHT;
                    end else begin
                        word_d = word_ins_c;
                        cnt_d  = cnt_inc_c;
                    end
                end
                RIGHT: begin
                    if (ws_fall_c) begin
                        push_c  = 1'b1;
                        word_d  = '0;
                        cnt_d   = '0;
                        state_d = LEFT;
                    end else begin
                        word_d = word_ins_c;
                        cnt_d  = cnt_inc_c;
                    end
                end
                default: begin
                    state_d = SYNC;
                    word_d  = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef I2S_RX_FIFO_EN
    pair_t head_c;
    logic  empty_c;
    logic  full_c;

    i2s_rx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .pair_t (pair_t)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_c),
        .i_data  (push_pair_c),
        .i_pop   (pop_c),
        .o_data  (head_c),
        .o_empty (empty_c),
        .o_full  (full_c)
    );

    assign pop_c     = ~empty_c & i_ready;
    assign ovf_evt_c = push_c & full_c & ~pop_c;
    assign o_valid   = ~empty_c;
    assign o_left    = head_c.left;
    assign o_right   = head_c.right;
`else
    logic  valid_q, valid_d;
    pair_t pair_q, pair_d;

    // Single holding register: accept a pair when empty or being popped.
    always_comb begin
        valid_d   = valid_q;
        pair_d    = pair_q;
        ovf_evt_c = 1'b0;
        pop_c     = valid_q & i_ready;
        if (pop_c) begin
            valid_d = 1'b0;
        end
        if (push_c) begin
            if (!valid_q || pop_c) begin
                pair_d  = push_pair_c;
                valid_d = 1'b1;
            end else begin
                ovf_evt_c = 1'b1;
            end
        end
    end

    // Holding register flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            pair_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pair_q  <= pair_d;
        end
    end

    assign o_valid = valid_q;
    assign o_left  = pair_q.left;
    assign o_right = pair_q.right;
`endif

    // Sticky overflow; a new overflow wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_evt_c) begin
            ovf_d = 1'b1;
        end else if (i_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    assign o_ovf = ovf_q;

    // Capture, FSM and flag registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sck_sync_q  <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sck_dly_q   <= 1'b0;
            ws_cur_q    <= 1'b0;
            state_q     <= SYNC;
            word_q      <= '0;
            cnt_q       <= '0;
            left_hold_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            sck_sync_q  <= sck_sync_d;
            ws_sync_q   <= ws_sync_d;
            sd_sync_q   <= sd_sync_d;
            sck_dly_q   <= sck_dly_d;
            ws_cur_q    <= ws_cur_d;
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            left_hold_q <= left_hold_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized I2S stream against a bit-stream/queue reference model.
module tb_i2s_rx;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FIFO_DEPTH = 4;
`ifdef I2S_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic              i_clk;
    logic              i_rst_n;
    logic              i_en;
    logic              i_sck;
    logic              i_ws;
    logic              i_sd;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_left;
    logic [DATA_W-1:0] o_right;
    logic              o_ovf;
    logic              i_ovf_clr;

    i2s_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_sck     (i_sck),
        .i_ws      (i_ws),
        .i_sd      (i_sd),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_left    (o_left),
        .o_right   (o_right),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks;
    int errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stream-level decoder state
    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
        int                due;
    } pend_t;

    pend_t             pend_q[$];
    logic [31:0]       mq[$];
    logic [31:0]       acc_q[$];
    bit                bits_q[$];
    bit                movf;
    int                cyc;
    bit                last_ws;
    bit                synced;
    bit                have_left;
    logic [DATA_W-1:0] left_w;
    bit                skip_first;
    bit                last_lsb;
    int                ready_mode;
    bit                clr_req;

    // First DATA_W received bits MSB-first, zero-padded when the slot is short.
    function automatic logic [DATA_W-1:0] pack_bits();
        logic [DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (i < bits_q.size()) w[DATA_W-1-i] = bits_q[i];
        end
        return w;
    endfunction

    // One SCK rising edge: the bit belongs to the channel of the previous WS.
    function automatic void model_event(input bit ws, input bit sd);
        logic [DATA_W-1:0] wv;
        pend_t p;
        bits_q.push_back(sd);
        if (ws != last_ws) begin
            wv = pack_bits();
            if (!last_ws) begin
                have_left = synced;
                left_w    = wv;
            end else begin
                if (synced && have_left && i_en) begin
                    p.l = left_w;
                    p.r = wv;
                    p.due = cyc + 3;
                    pend_q.push_back(p);
                end
                have_left = 1'b0;
                synced    = i_en;
            end
            bits_q.delete();
        end
        last_ws = ws;
    endfunction

    // Output buffer model: pop, then push if capacity allows, else overflow.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mq.delete();
            pend_q.delete();
            movf = 1'b0;
        end else begin : model_step
            bit          pop;
            bit          push;
            bit          evt;
            logic [31:0] np;
            cyc++;
            pop  = (mq.size() > 0) && i_ready;
            push = 1'b0;
            np   = '0;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                push = 1'b1;
                np   = {pend_q[0].l, pend_q[0].r};
                void'(pend_q.pop_front());
            end
            evt = 1'b0;
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < CAP) mq.push_back(np);
                else evt = 1'b1;
            end
            if (evt) movf = 1'b1;
            else if (i_ovf_clr) movf = 1'b0;
        end
    end

    // Per-cycle compare against the model.
    always @(posedge i_clk) begin
        #1;
        if (i_rst_n) begin
            chk("o_valid", 32'(o_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("o_left", 32'(o_left), 32'(mq[0][31:16]));
                chk("o_right", 32'(o_right), 32'(mq[0][15:0]));
            end
            chk("o_ovf", 32'(o_ovf), 32'(movf));
        end
    end

    // Record accepted pairs for literal checks.
    always @(posedge i_clk) begin
        if (i_rst_n && o_valid && i_ready) acc_q.push_back({o_left, o_right});
    end

    // Ready / clear driver.
    initial begin
        i_ready   = 1'b1;
        i_ovf_clr = 1'b0;
        forever begin
            @(negedge i_clk);
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'b0;
                default: i_ready = ($urandom_range(0, 3) != 0);
            endcase
            i_ovf_clr = clr_req || (ready_mode == 2 && $urandom_range(0, 31) == 0);
            clr_req   = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1);
    end

    // One SCK period: low half (WS/SD change), then rising edge.
    task automatic ev(input bit ws, input bit sd, input bit dis, input bit en, input bit rst);
        @(negedge i_clk);
        i_sck = 1'b0;
        i_ws  = ws;
        i_sd  = sd;
        if (dis) begin
            i_en = 1'b0;
            synced = 1'b0;
            have_left = 1'b0;
        end
        if (en) i_en = 1'b1;
        if (rst) begin
            i_rst_n = 1'b0;
            #1;
            chk("rst o_valid", 32'(o_valid), 32'd0);
            chk("rst o_left", 32'(o_left), 32'd0);
            chk("rst o_right", 32'(o_right), 32'd0);
            chk("rst o_ovf", 32'(o_ovf), 32'd0);
            last_ws = 1'b0;
            synced = 1'b0;
            have_left = 1'b0;
            bits_q.delete();
            repeat (3) @(negedge i_clk);
            i_rst_n = 1'b1;
        end else begin
            repeat (3) @(negedge i_clk);
        end
        @(negedge i_clk);
        i_sck = 1'b1;
        model_event(ws, sd);
        repeat (3) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int w,
                              input int dis_at, input int en_at, input int rst_at);
        bit sd;
        for (int e = 0; e < 2 * w; e++) begin
            if (e == 0 && skip_first) continue;
            if (e == 0) sd = last_lsb;
            else if (e < w) sd = l[w-e];
            else if (e == w) sd = l[0];
            else sd = r[2*w-e];
            ev(e >= w, sd, e == dis_at, e == en_at, e == rst_at);
        end
        last_lsb   = r[0];
        skip_first = 1'b0;
    endtask

    task automatic flush();
        ev(1'b0, last_lsb, 1'b0, 1'b0, 1'b0);
        skip_first = 1'b1;
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [15:0] l, input logic [15:0] r);
        chk({name, " count"}, 32'(acc_q.size() > idx), 32'd1);
        if (acc_q.size() > idx) begin
            chk({name, " left"}, 32'(acc_q[idx][31:16]), 32'(l));
            chk({name, " right"}, 32'(acc_q[idx][15:0]), 32'(r));
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        ready_mode = 0; clr_req = 1'b0;
        last_ws = 1'b0; synced = 1'b0; have_left = 1'b0; left_w = '0;
        skip_first = 1'b0; last_lsb = 1'b0; movf = 1'b0;
        i_rst_n = 1'b0; i_en = 1'b1; i_sck = 1'b0; i_ws = 1'b1; i_sd = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("reset o_valid", 32'(o_valid), 32'd0);
        chk("reset o_left", 32'(o_left), 32'd0);
        chk("reset o_right", 32'(o_right), 32'd0);
        chk("reset o_ovf", 32'(o_ovf), 32'd0);
        i_rst_n = 1'b1;
        ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Basic frame
        acc_q.delete();
        send_frame(32'hA5C3, 32'h1234, 16, -1, -1, -1);
        flush();
        repeat (6) @(negedge i_clk);
        chk("t1 pairs", 32'(acc_q.size()), 32'd1);
        chk_acc("t1", 0, 16'hA5C3, 16'h1234);

        // Long and short slots
        acc_q.delete();
        send_frame(32'hDEADBEEF, 32'h0F0F0F0F, 32, -1, -1, -1);
        send_frame(32'hABC, 32'h5A5, 12, -1, -1, -1);
        flush();
        repeat (6) @(negedge i_clk);
        chk_acc("t2 wide", 0, 16'hDEAD, 16'h0F0F);
        chk_acc("t2 narrow", 1, 16'hABC0, 16'h5A50);

        // Enable mid right word: partial frame dropped
        acc_q.delete();
        send_frame(32'h1111, 32'h2222, 16, 1, 24, -1);
        send_frame(32'h3333, 32'h4444, 16, -1, -1, -1);
        flush();
        repeat (6) @(negedge i_clk);
        chk("t3 pairs", 32'(acc_q.size()), 32'd1);
        chk_acc("t3", 0, 16'h3333, 16'h4444);

        acc_q.delete();
        ready_mode = 1;
`ifdef I2S_RX_FIFO_EN
        // FIFO back-pressure: five frames into four entries
        for (int k = 1; k <= 5; k++) begin
            send_frame(32'(k), 32'(16'h0100 + k), 16, -1, -1, -1);
        end
        flush();
        repeat (6) @(negedge i_clk);
        chk("t5 ovf", 32'(o_ovf), 32'd1);
        ready_mode = 0;
        repeat (10) @(negedge i_clk);
        chk("t5 pairs", 32'(acc_q.size()), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk_acc("t5 drain", k - 1, 16'(k), 16'(16'h0100 + k));
        end
        @(posedge i_clk); #2; clr_req = 1'b1;
        repeat (3) @(negedge i_clk);
`else
        // Holding register back-pressure: second frame dropped
        send_frame(32'h0101, 32'h0202, 16, -1, -1, -1);
        send_frame(32'h0303, 32'h0404, 16, -1, -1, -1);
        flush();
        repeat (6) @(negedge i_clk);
        chk("t4 ovf set", 32'(o_ovf), 32'd1);
        chk("t4 held valid", 32'(o_valid), 32'd1);
        chk("t4 held left", 32'(o_left), 32'h0101);
        chk("t4 held right", 32'(o_right), 32'h0202);
        @(posedge i_clk); #2; clr_req = 1'b1;
        repeat (3) @(negedge i_clk);
        chk("t4 ovf cleared", 32'(o_ovf), 32'd0);
        chk("t4 still left", 32'(o_left), 32'h0101);
        ready_mode = 0;
        repeat (4) @(negedge i_clk);
        chk("t4 pairs", 32'(acc_q.size()), 32'd1);
        chk_acc("t4", 0, 16'h0101, 16'h0202);
`endif

        // Reset mid word, then a clean frame
        acc_q.delete();
        send_frame(32'h7777, 32'h8888, 16, -1, -1, 5);
        send_frame(32'h9999, 32'h6666, 16, -1, -1, -1);
        flush();
        repeat (6) @(negedge i_clk);
        chk("t6 pairs", 32'(acc_q.size()), 32'd1);
        chk_acc("t6", 0, 16'h9999, 16'h6666);

        // Randomized frames, widths, back-pressure, enable drops and resets
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            int w;
            int dis_at;
            int en_at;
            int rst_at;
            w = int'($urandom_range(8, 32));
            dis_at = -1; en_at = -1; rst_at = -1;
            if ($urandom_range(0, 7) == 0) begin
                dis_at = int'($urandom_range(1, w));
                en_at  = int'($urandom_range(dis_at + 1, 2 * w - 1));
            end
            if ($urandom_range(0, 11) == 0) rst_at = int'($urandom_range(1, 2 * w - 1));
            send_frame($urandom, $urandom, w, dis_at, en_at, rst_at);
        end
        flush();
        ready_mode = 0;
        repeat (20) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
